// File: rtl/systolic_pkg.sv
// Shared sizing and south-edge post-processing for the 4x4 weight-stationary
// systolic matrix-multiply engine.
package systolic_pkg;

  localparam int DW     = 8;
  localparam int ACCW   = 24;
  localparam int QSHIFT = 0;
  localparam int N      = 4;

  localparam logic signed [ACCW-1:0] QMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};

  // Upper saturation only matters once the value is known to be non-negative,
  // because ReLU already maps every negative value to zero.
  function automatic logic [DW-1:0] quant_relu(input logic signed [ACCW-1:0] acc,
                                               input int                     shift);
    logic signed [ACCW-1:0] sh_s;
    logic [DW-1:0]          res_s;
    sh_s = acc >>> shift;
    if (sh_s[ACCW-1]) begin
      res_s = {DW{1'b0}};
    end else if (sh_s > QMAX) begin
      res_s = QMAX[DW-1:0];
    end else begin
      res_s = sh_s[DW-1:0];
    end
    return res_s;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One processing element: stationary weight, forwarded activation and
// south-flowing partial sum with a signed multiply-accumulate.
module systolic_pe
  import systolic_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load,
  input  logic [DW-1:0]          w_in,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [ACCW-1:0] p_in,
  output logic [DW-1:0]          w_out,
  output logic signed [DW-1:0]   a_out,
  output logic signed [ACCW-1:0] p_out
);

  logic [DW-1:0]          w_r;
  logic signed [DW-1:0]   a_r;
  logic signed [ACCW-1:0] p_r;
  logic signed [2*DW-1:0] prod_s;
  logic signed [ACCW-1:0] mac_s;

  assign prod_s = a_in * $signed(w_r);
  assign mac_s  = p_in + $signed({{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s});

  // Weight shift in load mode (which also flushes data), MAC in compute mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r <= {DW{1'b0}};
      a_r <= {DW{1'b0}};
      p_r <= {ACCW{1'b0}};
    end else if (en) begin
      if (load) begin
        w_r <= w_in;
        a_r <= {DW{1'b0}};
        p_r <= {ACCW{1'b0}};
      end else begin
        a_r <= a_in;
        p_r <= mac_s;
      end
    end
  end

  assign w_out = w_r;
  assign a_out = a_r;
  assign p_out = p_r;

endmodule

// File: rtl/systolic_array.sv
// 4x4 weight-stationary systolic array: weights shift down from the north,
// activations stream east, and the bottom row is quantized and rectified.
module systolic_array
  import systolic_pkg::*;
#(
  parameter int QSHIFT = systolic_pkg::QSHIFT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Wen,
  input  logic          pauseProcess,
  input  logic [DW-1:0] inp_north0,
  input  logic [DW-1:0] inp_north1,
  input  logic [DW-1:0] inp_north2,
  input  logic [DW-1:0] inp_north3,
  input  logic [DW-1:0] inp_west0,
  input  logic [DW-1:0] inp_west1,
  input  logic [DW-1:0] inp_west2,
  input  logic [DW-1:0] inp_west3,
  output logic [4:0]    count,
  output logic [DW-1:0] Activation_result12,
  output logic [DW-1:0] Activation_result13,
  output logic [DW-1:0] Activation_result14,
  output logic [DW-1:0] Activation_result15
);

  logic                   operationMode;
  logic [DW-1:0]          north_s [N];
  logic signed [DW-1:0]   west_s  [N];
  logic [DW-1:0]          w_s     [N][N];
  logic signed [DW-1:0]   a_s     [N][N];
  logic signed [ACCW-1:0] p_s     [N][N];
  logic [DW-1:0]          act_s   [N];
  logic [4:0]             count_r;
  logic                   unused_s;

  assign operationMode = Wen;

  assign north_s[0] = inp_north0;
  assign north_s[1] = inp_north1;
  assign north_s[2] = inp_north2;
  assign north_s[3] = inp_north3;
  assign west_s[0]  = $signed(inp_west0);
  assign west_s[1]  = $signed(inp_west1);
  assign west_s[2]  = $signed(inp_west2);
  assign west_s[3]  = $signed(inp_west3);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic [DW-1:0]          w_in_s;
      logic signed [DW-1:0]   a_in_s;
      logic signed [ACCW-1:0] p_in_s;

      if (r == 0) begin : g_north_edge
        assign w_in_s = north_s[c];
        assign p_in_s = {ACCW{1'b0}};
      end else begin : g_inner_row
        assign w_in_s = w_s[r-1][c];
        assign p_in_s = p_s[r-1][c];
      end

      if (c == 0) begin : g_west_edge
        assign a_in_s = west_s[r];
      end else begin : g_inner_col
        assign a_in_s = a_s[r][c-1];
      end

      systolic_pe u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (pauseProcess),
        .load  (operationMode),
        .w_in  (w_in_s),
        .a_in  (a_in_s),
        .p_in  (p_in_s),
        .w_out (w_s[r][c]),
        .a_out (a_s[r][c]),
        .p_out (p_s[r][c])
      );
    end
  end

  // South-edge quantize and ReLU, plus the array-edge outputs that feed nothing.
  always_comb begin
    unused_s = 1'b0;
    for (int c = 0; c < N; c++) begin
      act_s[c] = quant_relu(p_s[N-1][c], QSHIFT);
      unused_s = unused_s ^ (^w_s[N-1][c]) ^ (^a_s[c][N-1]);
    end
  end

  // Compute-cycle counter: cleared by weight loading, saturates at 31.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 5'd0;
    end else if (pauseProcess) begin
      if (operationMode) begin
        count_r <= 5'd0;
      end else if (count_r != 5'd31) begin
        count_r <= count_r + 5'd1;
      end
    end
  end

  assign count               = count_r;
  assign Activation_result12 = act_s[0];
  assign Activation_result13 = act_s[1];
  assign Activation_result14 = act_s[2];
  assign Activation_result15 = act_s[3];

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench: the driver pushes one expected record per clock edge and a
// monitor checks both the QSHIFT=0 and QSHIFT=2 builds shortly after each edge.
module tb_systolic_array;

  logic       clk = 1'b0;
  logic       rst;
  logic       Wen;
  logic       pauseProcess;
  logic [7:0] inp_north0, inp_north1, inp_north2, inp_north3;
  logic [7:0] inp_west0, inp_west1, inp_west2, inp_west3;
  logic [4:0] count, count_q;
  logic [7:0] r12, r13, r14, r15;
  logic [7:0] q12, q13, q14, q15;

  systolic_array #(.QSHIFT(0)) dut (
    .clk(clk), .rst(rst), .Wen(Wen), .pauseProcess(pauseProcess),
    .inp_north0(inp_north0), .inp_north1(inp_north1),
    .inp_north2(inp_north2), .inp_north3(inp_north3),
    .inp_west0(inp_west0), .inp_west1(inp_west1),
    .inp_west2(inp_west2), .inp_west3(inp_west3),
    .count(count),
    .Activation_result12(r12), .Activation_result13(r13),
    .Activation_result14(r14), .Activation_result15(r15)
  );

  systolic_array #(.QSHIFT(2)) dut_q (
    .clk(clk), .rst(rst), .Wen(Wen), .pauseProcess(pauseProcess),
    .inp_north0(inp_north0), .inp_north1(inp_north1),
    .inp_north2(inp_north2), .inp_north3(inp_north3),
    .inp_west0(inp_west0), .inp_west1(inp_west1),
    .inp_west2(inp_west2), .inp_west3(inp_west3),
    .count(count_q),
    .Activation_result12(q12), .Activation_result13(q13),
    .Activation_result14(q14), .Activation_result15(q15)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  cnt;
    logic [31:0] act;
    logic [31:0] actq;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          w_m[4][4];
  int          j_m;
  logic [4:0]  cnt_m;
  logic [31:0] act_m, actq_m;
  logic [31:0] xs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] qrelu(input int y, input int sh);
    int s;
    s = y >>> sh;
    if (s < 0) return 8'd0;
    else if (s > 127) return 8'd127;
    else return s[7:0];
  endfunction

  function automatic int dot(input int idx, input int c);
    int y;
    y = 0;
    for (int r = 0; r < 4; r++) y += int'($signed(xs[idx][8*r +: 8])) * w_m[r][c];
    return y;
  endfunction

  // One clock edge: drive inputs, predict the post-edge state, queue it.
  task automatic step(input logic wen, input logic pause, input logic [31:0] north);
    logic [31:0] west;
    int          idx;
    int          y;
    for (int r = 0; r < 4; r++) begin
      idx = j_m - r;
      if (!wen && pause && idx >= 0 && idx < xs.size()) west[8*r +: 8] = xs[idx][8*r +: 8];
      else if (!wen && pause) west[8*r +: 8] = 8'h00;
      else west[8*r +: 8] = 8'h5a;
    end
    Wen = wen;
    pauseProcess = pause;
    {inp_north3, inp_north2, inp_north1, inp_north0} = north;
    {inp_west3, inp_west2, inp_west1, inp_west0} = west;
    if (pause) begin
      if (wen) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 3; r >= 1; r--) w_m[r][c] = w_m[r-1][c];
          w_m[0][c] = int'($signed(north[8*c +: 8]));
        end
        j_m = 0;
        cnt_m = 5'd0;
        act_m = 32'd0;
        actq_m = 32'd0;
        xs.delete();
      end else begin
        for (int c = 0; c < 4; c++) begin
          idx = j_m - 3 - c;
          y = (idx >= 0 && idx < xs.size()) ? dot(idx, c) : 0;
          act_m[8*c +: 8] = qrelu(y, 0);
          actq_m[8*c +: 8] = qrelu(y, 2);
        end
        j_m++;
        if (cnt_m != 5'd31) cnt_m++;
      end
    end
    exp_q.push_back({cnt_m, act_m, actq_m});
    @(negedge clk);
  endtask

  task automatic compute(input int n);
    repeat (n) step(1'b0, 1'b1, 32'h33333333);
  endtask

  task automatic load_ones();
    repeat (4) step(1'b1, 1'b1, 32'h01010101);
  endtask

  // Monitor: one queued expectation per clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("count", 32'(count), 32'(mon_e.cnt));
      check("count_qshift2", 32'(count_q), 32'(mon_e.cnt));
      check("act12..15", {r15, r14, r13, r12}, mon_e.act);
      check("act12..15_qshift2", {q15, q14, q13, q12}, mon_e.actq);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    Wen = 1'b1;
    pauseProcess = 1'b1;
    {inp_north3, inp_north2, inp_north1, inp_north0} = 32'd0;
    {inp_west3, inp_west2, inp_west1, inp_west0} = 32'd0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) w_m[r][c] = 0;
    j_m = 0;
    cnt_m = 5'd0;
    act_m = 32'd0;
    actq_m = 32'd0;
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_act", {r15, r14, r13, r12}, 32'd0);
    check("reset_act_qshift2", {q15, q14, q13, q12}, 32'd0);
    #2 rst = 1'b0;

    // All-ones weights; 12 -> 3 in the QSHIFT=2 build, -20 -> 0; pause mid-stream.
    load_ones();
    repeat (4) xs.push_back(32'h01010101);
    xs.push_back(32'h03030303);
    xs.push_back(32'hfbfbfbfb);
    compute(5);
    repeat (3) step(1'b0, 1'b0, 32'h33333333);
    compute(9);

    // Identity weights: first value presented ends up in row 3.
    step(1'b1, 1'b1, 32'h01000000);
    step(1'b1, 1'b1, 32'h00010000);
    step(1'b1, 1'b1, 32'h00000100);
    step(1'b1, 1'b1, 32'h00000001);
    xs.push_back(32'h09070503);
    compute(8);

    // Five load edges, only the last four (127) retained; clamp and ReLU cases.
    step(1'b1, 1'b1, 32'h00000000);
    repeat (4) step(1'b1, 1'b1, 32'h7f7f7f7f);
    xs.push_back(32'h7f7f7f7f);
    xs.push_back(32'h80808080);
    xs.push_back(32'hff01ff01);
    xs.push_back(32'h00fd140a);
    compute(10);

    // Mode switch at count 6, then run count into saturation.
    load_ones();
    xs.push_back(32'h02020202);
    compute(6);
    load_ones();
    compute(40);

    // Asynchronous reset mid-stream.
    load_ones();
    xs.push_back(32'h04030201);
    compute(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrun_reset_count", 32'(count), 32'd0);
    check("midrun_reset_act", {r15, r14, r13, r12}, 32'd0);
    check("midrun_reset_act_qshift2", {q15, q14, q13, q12}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
